// File: rtl/reg_file_sb.sv
// -----------------------------------------------------------------------------
// reg_file_sb
//
// Register file with an integrated scoreboard for the decode/writeback stages
// of the pipelined CPU. Two asynchronous read ports, one synchronous write
// port, and a pending bit per register. Decode reserves a destination,
// writeback clears the reservation, and STALL is raised while either operand
// being read still waits on an in-flight result.
//
// Optional feature macro: REGFILE_BYPASS_EN
//   Defined   : a write in flight forwards IN to a read port that selects
//               INADDRESS (unless RESERVE retargets that same register in the
//               same cycle), and that port reports not busy.
//   Undefined : reads see only committed array/scoreboard state.
//
// Parameters
//   DATA_WIDTH    register width in bits (signed data)
//   ADDR_WIDTH    address width, NUM_REGS = 2**ADDR_WIDTH
//
// Ports
//   CLK           system clock, all state changes on posedge
//   RESET         synchronous active-high reset
//   IN            signed write data
//   INADDRESS     write register select
//   WRITE         write enable
//   OUT1ADDRESS   read port 1 select
//   OUT2ADDRESS   read port 2 select
//   RESERVE       mark RESADDRESS pending
//   RESADDRESS    register to reserve
//   OUT1, OUT2    signed read data
//   BUSY1, BUSY2  selected register is pending
//   STALL         BUSY1 | BUSY2
//   PENDING_COUNT number of pending registers, 0..NUM_REGS
// -----------------------------------------------------------------------------
module reg_file_sb #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 3
) (
   input  logic                         CLK,
   input  logic                         RESET,
   input  logic signed [DATA_WIDTH-1:0] IN,
   input  logic        [ADDR_WIDTH-1:0] INADDRESS,
   input  logic                         WRITE,
   input  logic        [ADDR_WIDTH-1:0] OUT1ADDRESS,
   input  logic        [ADDR_WIDTH-1:0] OUT2ADDRESS,
   input  logic                         RESERVE,
   input  logic        [ADDR_WIDTH-1:0] RESADDRESS,
   output logic signed [DATA_WIDTH-1:0] OUT1,
   output logic signed [DATA_WIDTH-1:0] OUT2,
   output logic                         BUSY1,
   output logic                         BUSY2,
   output logic                         STALL,
   output logic        [ADDR_WIDTH:0]   PENDING_COUNT
);

   localparam int NUM_REGS = 2 ** ADDR_WIDTH;

   logic signed [DATA_WIDTH-1:0] regs_q [NUM_REGS];
   logic signed [DATA_WIDTH-1:0] regs_d [NUM_REGS];
   logic        [NUM_REGS-1:0]   pend_q;
   logic        [NUM_REGS-1:0]   pend_d;
   logic        [ADDR_WIDTH:0]   cnt_q;
   logic        [ADDR_WIDTH:0]   cnt_d;
   logic                         inc_s;
   logic                         dec_s;
   logic                         byp1_s;
   logic                         byp2_s;

   // Next-state for the array and the scoreboard bits.
   always_comb begin
      regs_d = regs_q;
      pend_d = pend_q;
      if (WRITE) begin
         regs_d[INADDRESS] = IN;
         pend_d[INADDRESS] = 1'b0;
      end else begin
         pend_d = pend_q;
      end
      // Applied after the write so a same-address reserve keeps the bit set:
      // the new producer owns the register.
      if (RESERVE) begin
         pend_d[RESADDRESS] = 1'b1;
      end else begin
         pend_d = pend_d;
      end
   end

   // Counter tracks popcount incrementally: at most one rise (reserve) and one
   // fall (write) per cycle, so it can never leave 0..NUM_REGS.
   always_comb begin
      inc_s = RESERVE & pend_d[RESADDRESS] & ~pend_q[RESADDRESS];
      dec_s = WRITE & pend_q[INADDRESS] & ~pend_d[INADDRESS];
      cnt_d = cnt_q + {{ADDR_WIDTH{1'b0}}, inc_s} - {{ADDR_WIDTH{1'b0}}, dec_s};
   end

   // State registers with synchronous reset overriding write and reserve.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= {DATA_WIDTH{1'b0}};
         end
         pend_q <= {NUM_REGS{1'b0}};
         cnt_q  <= {(ADDR_WIDTH+1){1'b0}};
      end else begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= regs_d[i];
         end
         pend_q <= pend_d;
         cnt_q  <= cnt_d;
      end
   end

   // Forwarding select: only when the in-flight write is not immediately
   // re-reserved, otherwise the reader must still wait for the newer producer.
   always_comb begin
`ifdef REGFILE_BYPASS_EN
      byp1_s = WRITE & ~(RESERVE & (RESADDRESS == INADDRESS)) & (OUT1ADDRESS == INADDRESS);
      byp2_s = WRITE & ~(RESERVE & (RESADDRESS == INADDRESS)) & (OUT2ADDRESS == INADDRESS);
`else
      byp1_s = 1'b0;
      byp2_s = 1'b0;
`endif
   end

   // Asynchronous read ports with optional forwarding.
   always_comb begin
      if (byp1_s) begin
         OUT1  = IN;
         BUSY1 = 1'b0;
      end else begin
         OUT1  = regs_q[OUT1ADDRESS];
         BUSY1 = pend_q[OUT1ADDRESS];
      end
      if (byp2_s) begin
         OUT2  = IN;
         BUSY2 = 1'b0;
      end else begin
         OUT2  = regs_q[OUT2ADDRESS];
         BUSY2 = pend_q[OUT2ADDRESS];
      end
      STALL         = BUSY1 | BUSY2;
      PENDING_COUNT = cnt_q;
   end

endmodule

// File: tb/tb_reg_file_sb.sv
// -----------------------------------------------------------------------------
// tb_reg_file_sb
//
// Directed bench for reg_file_sb. Stimulus drives one vector per cycle just
// after the rising edge and queues the hand-computed expected read-port
// values; a monitor pops and compares on the falling edge of the same cycle.
// Expectations for the forwarding cycles follow REGFILE_BYPASS_EN.
// -----------------------------------------------------------------------------
module tb_reg_file_sb;

   logic              CLK;
   logic              RESET;
   logic signed [7:0] IN;
   logic        [2:0] INADDRESS;
   logic              WRITE;
   logic        [2:0] OUT1ADDRESS;
   logic        [2:0] OUT2ADDRESS;
   logic              RESERVE;
   logic        [2:0] RESADDRESS;
   logic signed [7:0] OUT1;
   logic signed [7:0] OUT2;
   logic              BUSY1;
   logic              BUSY2;
   logic              STALL;
   logic        [3:0] PENDING_COUNT;

   typedef struct {
      logic signed [7:0] o1;
      logic signed [7:0] o2;
      logic              b1;
      logic              b2;
      logic              st;
      logic        [3:0] cnt;
      string             name;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   checks = 0;
   int   errors = 0;

   reg_file_sb #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) dut (
      .CLK(CLK), .RESET(RESET), .IN(IN), .INADDRESS(INADDRESS), .WRITE(WRITE),
      .OUT1ADDRESS(OUT1ADDRESS), .OUT2ADDRESS(OUT2ADDRESS),
      .RESERVE(RESERVE), .RESADDRESS(RESADDRESS),
      .OUT1(OUT1), .OUT2(OUT2), .BUSY1(BUSY1), .BUSY2(BUSY2),
      .STALL(STALL), .PENDING_COUNT(PENDING_COUNT)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Drive one cycle's inputs just after the rising edge.
   task automatic apply(input logic rst, input logic w, input logic [2:0] ia,
                        input logic signed [7:0] din, input logic r,
                        input logic [2:0] ra, input logic [2:0] a1,
                        input logic [2:0] a2);
      @(posedge CLK);
      #1;
      RESET = rst; WRITE = w; INADDRESS = ia; IN = din;
      RESERVE = r; RESADDRESS = ra; OUT1ADDRESS = a1; OUT2ADDRESS = a2;
   endtask

   task automatic idle(input logic [2:0] a1, input logic [2:0] a2);
      apply(1'b0, 1'b0, 3'd0, 8'sd0, 1'b0, 3'd0, a1, a2);
   endtask

   task automatic push_exp(input string name, input logic signed [7:0] o1,
                           input logic signed [7:0] o2, input logic b1,
                           input logic b2, input logic st, input logic [3:0] cnt);
      exp_t e;
      e.name = name; e.o1 = o1; e.o2 = o2; e.b1 = b1; e.b2 = b2; e.st = st; e.cnt = cnt;
      exp_q.push_back(e);
   endtask

   // Monitor: compare the pending expectation mid-cycle, away from the edge.
   always @(negedge CLK) begin
      if (exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         checks = checks + 1;
         if (OUT1 !== mon_e.o1 || OUT2 !== mon_e.o2 || BUSY1 !== mon_e.b1 ||
             BUSY2 !== mon_e.b2 || STALL !== mon_e.st || PENDING_COUNT !== mon_e.cnt) begin
            errors = errors + 1;
            $display("FAIL %s: got out1=%0d out2=%0d busy1=%b busy2=%b stall=%b cnt=%0d, want out1=%0d out2=%0d busy1=%b busy2=%b stall=%b cnt=%0d",
                     mon_e.name, OUT1, OUT2, BUSY1, BUSY2, STALL, PENDING_COUNT,
                     mon_e.o1, mon_e.o2, mon_e.b1, mon_e.b2, mon_e.st, mon_e.cnt);
         end
      end
   end

   initial begin
      RESET = 1'b1; WRITE = 1'b0; INADDRESS = 3'd0; IN = 8'sd0;
      RESERVE = 1'b0; RESADDRESS = 3'd0; OUT1ADDRESS = 3'd0; OUT2ADDRESS = 3'd0;

      apply(1'b1, 1'b0, 3'd0, 8'sd0, 1'b0, 3'd0, 3'd0, 3'd0);
      apply(1'b1, 1'b0, 3'd0, 8'sd0, 1'b0, 3'd0, 3'd0, 3'd0);

      // Reset state on every register.
      for (int i = 0; i < 8; i++) begin
         idle(3'(i), 3'(7 - i));
         push_exp("reset_read", 8'sd0, 8'sd0, 1'b0, 1'b0, 1'b0, 4'd0);
      end

      // Plain write of a negative value, read on both ports.
      apply(1'b0, 1'b1, 3'd3, -8'sd5, 1'b0, 3'd0, 3'd0, 3'd0);
      idle(3'd3, 3'd3);
      push_exp("write_r3_neg5", -8'sd5, -8'sd5, 1'b0, 1'b0, 1'b0, 4'd0);

      // Reserve R2 then R5 on consecutive edges.
      apply(1'b0, 1'b0, 3'd0, 8'sd0, 1'b1, 3'd2, 3'd2, 3'd5);
      apply(1'b0, 1'b0, 3'd0, 8'sd0, 1'b1, 3'd5, 3'd2, 3'd5);
      push_exp("reserve_r2_only", 8'sd0, 8'sd0, 1'b1, 1'b0, 1'b1, 4'd1);
      idle(3'd2, 3'd5);
      push_exp("reserve_r2_r5", 8'sd0, 8'sd0, 1'b1, 1'b1, 1'b1, 4'd2);

      // Writeback of R2 with R2 selected on port 1.
      apply(1'b0, 1'b1, 3'd2, 8'sd7, 1'b0, 3'd0, 3'd2, 3'd5);
`ifdef REGFILE_BYPASS_EN
      push_exp("wb_r2_precommit", 8'sd7, 8'sd0, 1'b0, 1'b1, 1'b1, 4'd2);
`else
      push_exp("wb_r2_precommit", 8'sd0, 8'sd0, 1'b1, 1'b1, 1'b1, 4'd2);
`endif
      idle(3'd2, 3'd5);
      push_exp("wb_r2_commit", 8'sd7, 8'sd0, 1'b0, 1'b1, 1'b1, 4'd1);

      // Same-edge write and reserve of R4: never forwarded.
      apply(1'b0, 1'b1, 3'd4, 8'sd9, 1'b1, 3'd4, 3'd4, 3'd4);
      push_exp("wr_res_r4_precommit", 8'sd0, 8'sd0, 1'b0, 1'b0, 1'b0, 4'd1);
      idle(3'd4, 3'd3);
      push_exp("wr_res_r4_commit", 8'sd9, -8'sd5, 1'b1, 1'b0, 1'b1, 4'd2);
      apply(1'b0, 1'b0, 3'd0, 8'sd0, 1'b1, 3'd4, 3'd4, 3'd3);
      idle(3'd4, 3'd3);
      push_exp("rereserve_r4", 8'sd9, -8'sd5, 1'b1, 1'b0, 1'b1, 4'd2);

      // Write R5 (pending, clears) while reserving R0: net count unchanged.
      apply(1'b0, 1'b1, 3'd5, 8'sd20, 1'b1, 3'd0, 3'd1, 3'd1);
      idle(3'd5, 3'd0);
      push_exp("wr_r5_res_r0", 8'sd20, 8'sd0, 1'b0, 1'b1, 1'b1, 4'd2);

      // Forwarding case on R6.
      apply(1'b0, 1'b0, 3'd0, 8'sd0, 1'b1, 3'd6, 3'd1, 3'd1);
      apply(1'b0, 1'b1, 3'd6, 8'sd100, 1'b0, 3'd0, 3'd6, 3'd0);
`ifdef REGFILE_BYPASS_EN
      push_exp("bypass_r6_precommit", 8'sd100, 8'sd0, 1'b0, 1'b1, 1'b1, 4'd3);
`else
      push_exp("bypass_r6_precommit", 8'sd0, 8'sd0, 1'b1, 1'b1, 1'b1, 4'd3);
`endif
      idle(3'd6, 3'd1);
      push_exp("wb_r6_release", 8'sd100, 8'sd0, 1'b0, 1'b0, 1'b0, 4'd2);

      // Plain write of a non-pending register keeps its bit clear.
      apply(1'b0, 1'b1, 3'd1, -8'sd128, 1'b0, 3'd0, 3'd7, 3'd7);
      idle(3'd1, 3'd6);
      push_exp("plain_write_r1", -8'sd128, 8'sd100, 1'b0, 1'b0, 1'b0, 4'd2);

      // Fill the scoreboard, then re-reserve: count saturates at 8.
      for (int i = 0; i < 8; i++) begin
         apply(1'b0, 1'b0, 3'd0, 8'sd0, 1'b1, 3'(i), 3'd7, 3'd3);
      end
      idle(3'd7, 3'd3);
      push_exp("all_pending", 8'sd0, -8'sd5, 1'b1, 1'b1, 1'b1, 4'd8);
      apply(1'b0, 1'b0, 3'd0, 8'sd0, 1'b1, 3'd0, 3'd7, 3'd3);
      idle(3'd7, 3'd3);
      push_exp("no_wrap", 8'sd0, -8'sd5, 1'b1, 1'b1, 1'b1, 4'd8);

      // Reset wins over a simultaneous write and reserve.
      apply(1'b1, 1'b1, 3'd3, 8'sd55, 1'b1, 3'd3, 3'd3, 3'd6);
      idle(3'd3, 3'd6);
      push_exp("reset_override", 8'sd0, 8'sd0, 1'b0, 1'b0, 1'b0, 4'd0);
      idle(3'd1, 3'd2);
      push_exp("reset_clears_all", 8'sd0, 8'sd0, 1'b0, 1'b0, 1'b0, 4'd0);

      // Drain the scoreboard within a bounded number of cycles.
      for (int k = 0; k < 10 && exp_q.size() != 0; k++) begin
         @(posedge CLK);
      end
      if (exp_q.size() != 0) begin
         errors = errors + 1;
         $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
      end
      #1;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
